// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache and D-cache refill paths.
// Optional watchdog on the WAIT state is enabled with `define ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_grant,
  output logic              i_rsp_valid,
  input  logic              d_req_valid,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_req_we,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_grant,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                i_grant_q, i_grant_d;
  logic                d_grant_q, d_grant_d;
  logic                i_rsp_valid_q, i_rsp_valid_d;
  logic                d_rsp_valid_q, d_rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d;
  // High when the D side was served last, so the I side wins the next tie.
  logic                last_d_q, last_d_d;
  logic                i_elig, d_elig, pick_d;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_err_q, timeout_err_d;
`else
  logic [31:0]         unused_timeout_cyc;
  assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
`endif

  // The stale re-request held during a response pulse must not win the port again.
  assign i_elig = i_req_valid && !i_rsp_valid_q;
  assign d_elig = d_req_valid && !d_rsp_valid_q;
  assign pick_d = d_elig && (!i_elig || !last_d_q);

  always_comb begin
    state_d         = state_q;
    i_grant_d       = i_grant_q;
    d_grant_d       = d_grant_q;
    i_rsp_valid_d   = 1'b0;
    d_rsp_valid_d   = 1'b0;
    rsp_data_d      = rsp_data_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_addr_d      = mem_addr_q;
    mem_we_d        = mem_we_q;
    mem_wdata_d     = mem_wdata_q;
    last_d_d        = last_d_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d           = cnt_q;
    timeout_err_d   = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_elig || d_elig) begin
          if (pick_d) begin
            mem_addr_d  = d_req_addr;
            mem_we_d    = d_req_we;
            mem_wdata_d = d_req_wdata;
            d_grant_d   = 1'b1;
          end else begin
            mem_addr_d  = i_req_addr;
            mem_we_d    = 1'b0;
            mem_wdata_d = '0;
            i_grant_d   = 1'b1;
          end
          mem_req_valid_d = 1'b1;
          state_d         = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = ST_WAIT;
`ifdef ARB_TIMEOUT_EN
          cnt_d           = '0;
`endif
        end
      end

      ST_WAIT: begin
        if (mem_rsp_valid) begin
          rsp_data_d    = mem_rsp_data;
          i_rsp_valid_d = i_grant_q;
          d_rsp_valid_d = d_grant_q;
          i_grant_d     = 1'b0;
          d_grant_d     = 1'b0;
          last_d_d      = d_grant_q;
          state_d       = ST_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        // A response arriving on the timeout cycle wins over the watchdog.
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          rsp_data_d    = '0;
          i_rsp_valid_d = i_grant_q;
          d_rsp_valid_d = d_grant_q;
          i_grant_d     = 1'b0;
          d_grant_d     = 1'b0;
          last_d_d      = d_grant_q;
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      default: begin
        state_d         = ST_IDLE;
        i_grant_d       = 1'b0;
        d_grant_d       = 1'b0;
        mem_req_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q         <= ST_IDLE;
      i_grant_q       <= 1'b0;
      d_grant_q       <= 1'b0;
      i_rsp_valid_q   <= 1'b0;
      d_rsp_valid_q   <= 1'b0;
      rsp_data_q      <= '0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_we_q        <= 1'b0;
      mem_wdata_q     <= '0;
      busy_q          <= 1'b0;
      last_d_q        <= 1'b1;
    end else begin
      state_q         <= state_d;
      i_grant_q       <= i_grant_d;
      d_grant_q       <= d_grant_d;
      i_rsp_valid_q   <= i_rsp_valid_d;
      d_rsp_valid_q   <= d_rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_addr_q      <= mem_addr_d;
      mem_we_q        <= mem_we_d;
      mem_wdata_q     <= mem_wdata_d;
      busy_q          <= busy_d;
      last_d_q        <= last_d_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign i_grant       = i_grant_q;
  assign d_grant       = d_grant_q;
  assign i_rsp_valid   = i_rsp_valid_q;
  assign d_rsp_valid   = d_rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_we        = mem_we_q;
  assign mem_wdata     = mem_wdata_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs driven and outputs sampled on the falling edge.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        i_req_valid;
  logic [31:0] i_req_addr;
  logic        i_grant;
  logic        i_rsp_valid;
  logic        d_req_valid;
  logic [31:0] d_req_addr;
  logic        d_req_we;
  logic [31:0] d_req_wdata;
  logic        d_grant;
  logic        d_rsp_valid;
  logic [31:0] rsp_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        busy;
  logic        timeout_err;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_grant(i_grant), .i_rsp_valid(i_rsp_valid),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
    .d_grant(d_grant), .d_rsp_valid(d_rsp_valid), .rsp_data(rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    i_req_valid = 0; i_req_addr = 0; d_req_valid = 0; d_req_addr = 0; d_req_we = 0; d_req_wdata = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
    tick(); tick();
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_grants", {30'd0, i_grant, d_grant}, 0);
    check("reset_rsp", {30'd0, i_rsp_valid, d_rsp_valid}, 0);
    check("reset_mem_req_valid", {31'd0, mem_req_valid}, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_timeout_err", {31'd0, timeout_err}, 0);
    RESET = 1'b1;
    tick();
    check("post_reset_busy", {31'd0, busy}, 0);
  endtask

  task automatic test_single_i_read();
    i_req_valid = 1; i_req_addr = 32'h0000_1000;
    tick();
    check("ird_grant", {30'd0, i_grant, d_grant}, 2'b10);
    check("ird_req_valid", {31'd0, mem_req_valid}, 1);
    check("ird_addr", mem_addr, 32'h1000);
    check("ird_we", {31'd0, mem_we}, 0);
    check("ird_busy", {31'd0, busy}, 1);
    mem_req_ready = 1;
    tick();
    check("ird_req_dropped", {31'd0, mem_req_valid}, 0);
    check("ird_no_early_rsp", {31'd0, i_rsp_valid}, 0);
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'hDEAD_BEEF;
    tick();
    check("ird_rsp_valid", {30'd0, i_rsp_valid, d_rsp_valid}, 2'b10);
    check("ird_rsp_data", rsp_data, 32'hDEAD_BEEF);
    check("ird_grant_cleared", {30'd0, i_grant, d_grant}, 0);
    check("ird_idle", {31'd0, busy}, 0);
    mem_rsp_valid = 0; mem_rsp_data = 0; i_req_valid = 0;
    tick();
    check("ird_rsp_pulse_end", {31'd0, i_rsp_valid}, 0);
    check("ird_rsp_data_held", rsp_data, 32'hDEAD_BEEF);
    check("ird_no_regrant", {31'd0, busy}, 0);
  endtask

  task automatic test_d_write();
    d_req_valid = 1; d_req_we = 1; d_req_addr = 32'h2004; d_req_wdata = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("dwr_req_valid", {31'd0, mem_req_valid}, 1);
      check("dwr_grant", {30'd0, i_grant, d_grant}, 2'b01);
      check("dwr_addr", mem_addr, 32'h2004);
      check("dwr_we", {31'd0, mem_we}, 1);
      check("dwr_wdata", mem_wdata, 32'h1234_5678);
      if (k == 3) mem_req_ready = 1;
    end
    tick();
    check("dwr_req_dropped", {31'd0, mem_req_valid}, 0);
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h0000_A5A5;
    tick();
    check("dwr_rsp_valid", {30'd0, i_rsp_valid, d_rsp_valid}, 2'b01);
    check("dwr_rsp_data", rsp_data, 32'h0000_A5A5);
    mem_rsp_valid = 0; d_req_valid = 0; d_req_we = 0;
    tick();
    check("dwr_rsp_pulse_end", {31'd0, d_rsp_valid}, 0);
    check("dwr_idle", {31'd0, busy}, 0);
  endtask

  task automatic test_round_robin();
    // Lone I read after a D write: the write fields must not leak into the I request.
    i_req_valid = 1; i_req_addr = 32'h3000;
    tick();
    check("rr_i_we_zero", {31'd0, mem_we}, 0);
    check("rr_i_wdata_zero", mem_wdata, 0);
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h11;
    tick();
    mem_rsp_valid = 0; i_req_valid = 0;
    tick();
    // I served last, so a fresh tie goes to D.
    i_req_valid = 1; i_req_addr = 32'h3100; d_req_valid = 1; d_req_addr = 32'h3200;
    tick();
    check("rr_tie_to_d", {30'd0, i_grant, d_grant}, 2'b01);
    check("rr_tie_addr", mem_addr, 32'h3200);
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h22;
    tick();
    check("rr_d_rsp", {30'd0, i_rsp_valid, d_rsp_valid}, 2'b01);
    mem_rsp_valid = 0; d_req_valid = 0;
    tick();
    check("rr_then_i", {30'd0, i_grant, d_grant}, 2'b10);
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h33;
    tick();
    check("rr_i_rsp", {30'd0, i_rsp_valid, d_rsp_valid}, 2'b10);
    mem_rsp_valid = 0; i_req_valid = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_addr;
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    // From reset with both held: I, D, I, D, with no I repeat in its own response cycle.
    i_req_valid = 1; i_req_addr = 32'h100; d_req_valid = 1; d_req_addr = 32'h200; d_req_we = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_addr = (k % 2 == 0) ? 32'h100 : 32'h200;
      check("b2b_grant", {30'd0, i_grant, d_grant}, (k % 2 == 0) ? 2'b10 : 2'b01);
      check("b2b_addr", mem_addr, exp_addr);
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h1000 + k;
      tick();
      check("b2b_rsp", {30'd0, i_rsp_valid, d_rsp_valid}, (k % 2 == 0) ? 2'b10 : 2'b01);
      check("b2b_rsp_data", rsp_data, 32'h1000 + k);
      check("b2b_grant_clear", {30'd0, i_grant, d_grant}, 0);
      mem_rsp_valid = 0;
    end
    i_req_valid = 0; d_req_valid = 0;
    tick();
    check("b2b_idle", {31'd0, busy}, 0);
  endtask

  task automatic test_withdraw();
    i_req_valid = 1; i_req_addr = 32'h4000;
    tick();
    check("wd_grant", {30'd0, i_grant, d_grant}, 2'b10);
    i_req_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h77;
    tick();
    check("wd_rsp_valid", {31'd0, i_rsp_valid}, 1);
    check("wd_rsp_data", rsp_data, 32'h77);
    mem_rsp_valid = 0;
    tick();
  endtask

  task automatic test_timeout();
`ifdef ARB_TIMEOUT_EN
    i_req_valid = 1; i_req_addr = 32'h5000;
    tick();
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    for (int k = 1; k <= 8; k++) begin
      check("to_no_early_err", {31'd0, timeout_err}, 0);
      check("to_waiting", {31'd0, busy}, 1);
      tick();
    end
    check("to_err_pulse", {31'd0, timeout_err}, 1);
    check("to_i_rsp", {30'd0, i_rsp_valid, d_rsp_valid}, 2'b10);
    check("to_rsp_data_zero", rsp_data, 0);
    check("to_idle", {31'd0, busy}, 0);
    i_req_valid = 0;
    d_req_valid = 1; d_req_addr = 32'h6000; d_req_we = 1; d_req_wdata = 32'h99;
    tick();
    check("to_err_cleared", {31'd0, timeout_err}, 0);
    check("to_next_d_grant", {30'd0, i_grant, d_grant}, 2'b01);
    check("to_next_d_addr", mem_addr, 32'h6000);
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h88;
    tick();
    check("to_d_rsp", {30'd0, i_rsp_valid, d_rsp_valid}, 2'b01);
    check("to_d_no_err", {31'd0, timeout_err}, 0);
    mem_rsp_valid = 0; d_req_valid = 0; d_req_we = 0;
    tick();
`endif
  endtask

  task automatic test_reset_in_wait();
    i_req_valid = 1; i_req_addr = 32'h7000;
    tick();
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    check("rw_in_wait", {31'd0, busy}, 1);
    RESET = 1'b0; i_req_valid = 0;
    #1;
    check("rw_async_busy", {31'd0, busy}, 0);
    check("rw_async_grant", {30'd0, i_grant, d_grant}, 0);
    check("rw_async_addr", mem_addr, 0);
    tick();
    RESET = 1'b1; mem_rsp_valid = 1; mem_rsp_data = 32'h55;
    tick();
    check("rw_no_rsp", {30'd0, i_rsp_valid, d_rsp_valid}, 0);
    check("rw_rsp_data", rsp_data, 0);
    check("rw_idle", {31'd0, busy}, 0);
    mem_rsp_valid = 0;
    tick();
    check("rw_still_no_rsp", {30'd0, i_rsp_valid, d_rsp_valid}, 0);
  endtask

  initial begin
    test_reset();
    test_single_i_read();
    test_d_write();
    test_round_robin();
    test_back_to_back();
    test_withdraw();
    test_timeout();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
